// File: rtl/adder_pkg.sv
// Shared types and constants for the switch-adder input controller.
// Operand widths, sum width, the default debounce length and the FSM state type.
package adder_pkg;

    localparam int OP_W          = 4;
    localparam int SUM_W         = 5;
    localparam int DEB_COUNT_DEF = 1_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and rising-edge pulse.
// The debounced level only follows the input after DEB_COUNT consecutive mismatching cycles.
module btn_debounce
    import adder_pkg::*;
#(
    parameter int DEB_COUNT = DEB_COUNT_DEF,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_COUNT - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn};
            level_d <= level_q;
            // Any cycle that agrees with the current level restarts the stability window.
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pulse = level_q & ~level_d;

endmodule

// File: rtl/adder_input_ctrl.sv
// Front end of the 4-bit switch adder: button conditioning, operand latch, registered sum
// and the IDLE/LOAD/SHOW sequencer that drives the seven-segment display stage.
module adder_input_ctrl
    import adder_pkg::*;
#(
    parameter int DEB_COUNT = DEB_COUNT_DEF,
    parameter int CNT_W     = 20
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [OP_W-1:0]  sw_a,
    input  logic [OP_W-1:0]  sw_b,
    input  logic             btn_calc,
    input  logic             btn_clr,
    output logic [OP_W-1:0]  num1,
    output logic [OP_W-1:0]  num2,
    output logic [SUM_W-1:0] sum,
    output logic             sum_valid,
    output logic             overflow,
    output logic             blank
);

    logic              calc_p;
    logic              clr_p;
    logic [OP_W-1:0]   sw_a_m, sw_a_s;
    logic [OP_W-1:0]   sw_b_m, sw_b_s;
    logic [SUM_W-1:0]  sum_next;
    state_t            state_q, state_d;

    btn_debounce #(.DEB_COUNT(DEB_COUNT), .CNT_W(CNT_W)) u_deb_calc (
        .clk   (clk),
        .rst_n (clr_n),
        .btn   (btn_calc),
        .pulse (calc_p)
    );

    btn_debounce #(.DEB_COUNT(DEB_COUNT), .CNT_W(CNT_W)) u_deb_clr (
        .clk   (clk),
        .rst_n (clr_n),
        .btn   (btn_clr),
        .pulse (clr_p)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sw_a_m <= '0;
            sw_a_s <= '0;
            sw_b_m <= '0;
            sw_b_s <= '0;
        end else begin
            sw_a_m <= sw_a;
            sw_a_s <= sw_a_m;
            sw_b_m <= sw_b;
            sw_b_s <= sw_b_m;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_p) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (calc_p) state_d = LOAD;
                LOAD:    state_d = SHOW;
                SHOW:    if (calc_p) state_d = LOAD;
                default: state_d = IDLE;
            endcase
        end
    end

    assign sum_next = {1'b0, num1} + {1'b0, num2};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            num1     <= '0;
            num2     <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else if (clr_p) begin
            num1     <= '0;
            num2     <= '0;
            sum      <= '0;
            overflow <= 1'b0;
        end else begin
            // Operands are held in LOAD so the sum always matches what is displayed.
            if (calc_p && state_q != LOAD) begin
                num1 <= sw_a_s;
                num2 <= sw_b_s;
            end
            if (state_q == LOAD) begin
                sum      <= sum_next;
                overflow <= sum_next[SUM_W-1];
            end
        end
    end

    assign sum_valid = (state_q == SHOW);
    assign blank     = (state_q == IDLE);

endmodule

// File: tb/tb_adder_input_ctrl.sv
// Directed bench for adder_input_ctrl with a short debounce window (DEB_COUNT=4).
// Operand/sum vectors come from a table; reset, bounce and clear races are hand sequences.
module tb_adder_input_ctrl;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       clr_n;
    logic [3:0] sw_a, sw_b;
    logic       btn_calc, btn_clr;
    logic [3:0] num1, num2;
    logic [4:0] sum;
    logic       sum_valid, overflow, blank;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] s;
        logic       ov;
    } vec_t;

    vec_t vecs[7];

    adder_input_ctrl #(.DEB_COUNT(DEB), .CNT_W(3)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .sw_a      (sw_a),
        .sw_b      (sw_b),
        .btn_calc  (btn_calc),
        .btn_clr   (btn_clr),
        .num1      (num1),
        .num2      (num2),
        .sum       (sum),
        .sum_valid (sum_valid),
        .overflow  (overflow),
        .blank     (blank)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_num1"}, int'(num1), 0);
        check({tag, "_num2"}, int'(num2), 0);
        check({tag, "_sum"}, int'(sum), 0);
        check({tag, "_valid"}, int'(sum_valid), 0);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_blank"}, int'(blank), 1);
    endtask

    // mode 0: clean calc press, 1: bouncing calc press, 2: calc and clear together
    task automatic window(input int mode, input int a, input int b, output int loads);
        logic prev_load, is_load, lvl;
        prev_load = 1'b0;
        loads = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            is_load = (blank == 1'b0) && (sum_valid == 1'b0);
            if (prev_load) check("load_to_show", int'(sum_valid), 1);
            if (is_load) begin
                loads++;
                check("load_num1", int'(num1), a);
                check("load_num2", int'(num2), b);
            end
            prev_load = is_load;
            case (mode)
                1:       lvl = (c < 2) || (c >= 4 && c < 14);
                default: lvl = (c < 10);
            endcase
            btn_calc = lvl;
            btn_clr  = (mode == 2) && (c < 10);
        end
    endtask

    initial begin
        int loads;
        int n;
        vecs[0] = '{a: 4'd3,  b: 4'd5,  s: 5'd8,  ov: 1'b0};
        vecs[1] = '{a: 4'd15, b: 4'd15, s: 5'd30, ov: 1'b1};
        vecs[2] = '{a: 4'd9,  b: 4'd6,  s: 5'd15, ov: 1'b0};
        vecs[3] = '{a: 4'd0,  b: 4'd0,  s: 5'd0,  ov: 1'b0};
        vecs[4] = '{a: 4'd8,  b: 4'd8,  s: 5'd16, ov: 1'b1};
        vecs[5] = '{a: 4'd15, b: 4'd0,  s: 5'd15, ov: 1'b0};
        vecs[6] = '{a: 4'd1,  b: 4'd15, s: 5'd16, ov: 1'b1};

        clr_n = 1'b0; sw_a = 4'd0; sw_b = 4'd0; btn_calc = 1'b0; btn_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("rst");
        clr_n = 1'b1;
        repeat (8) @(negedge clk);
        check_idle_zero("post_rst");

        foreach (vecs[i]) begin
            sw_a = vecs[i].a;
            sw_b = vecs[i].b;
            repeat (3) @(negedge clk);
            window(0, int'(vecs[i].a), int'(vecs[i].b), loads);
            check("vec_loads", loads, 1);
            check("vec_num1", int'(num1), int'(vecs[i].a));
            check("vec_num2", int'(num2), int'(vecs[i].b));
            check("vec_sum", int'(sum), int'(vecs[i].s));
            check("vec_ovf", int'(overflow), int'(vecs[i].ov));
            check("vec_valid", int'(sum_valid), 1);
            check("vec_blank", int'(blank), 0);
        end

        sw_a = 4'd3; sw_b = 4'd5;
        repeat (3) @(negedge clk);
        window(1, 3, 5, loads);
        check("bounce_loads", loads, 1);
        check("bounce_sum", int'(sum), 8);
        sw_a = 4'd12; sw_b = 4'd13;
        repeat (6) @(negedge clk);
        check("stable_sum", int'(sum), 8);
        check("stable_num1", int'(num1), 3);
        check("stable_num2", int'(num2), 5);
        check("stable_valid", int'(sum_valid), 1);

        window(2, 0, 0, loads);
        check("race_loads", loads, 0);
        check_idle_zero("race");

        sw_a = 4'd7; sw_b = 4'd2;
        repeat (3) @(negedge clk);
        btn_calc = 1'b1;
        n = 0;
        while (!(blank == 1'b0 && sum_valid == 1'b0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_load", int'(n < 20), 1);
        clr_n = 1'b0;
        #1;
        check_idle_zero("async_rst");
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(blank == 1'b0 && sum_valid == 1'b0) && n < 20);
        check("held_latency", n, DEB + 3);
        repeat (4) @(negedge clk);
        check("held_sum", int'(sum), 9);
        check("held_num1", int'(num1), 7);
        check("held_valid", int'(sum_valid), 1);
        btn_calc = 1'b0;
        repeat (10) @(negedge clk);
        check("held_once", int'(sum_valid), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_input_ctrl.md
# adder_input_ctrl

Front-end stage for the 4-bit switch adder. It synchronises and debounces the raw CALCULATE and CLEAR push-buttons and converts each press into a single-cycle pulse. It latches the two switch operands on CALCULATE and produces a registered 5-bit sum with valid and overflow flags. It drives the seven-segment display stage directly: operands, sum, overflow (shown as 'E') and blanking on clear.

## Interface
Parameters:
- DEB_COUNT, 1_000_000: consecutive stable cycles required before a debounced level changes (20 ms at 50 MHz).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W > DEB_COUNT.

Ports:
- clk  in  1  system clock; only clock in the block.
- clr_n  in  1  reset; asynchronous assert, active-low. Release is synchronous to clk in the board wrapper.
- sw_a  in  4  operand A switches; raw and asynchronous.
- sw_b  in  4  operand B switches; raw and asynchronous.
- btn_calc  in  1  CALCULATE button; raw, active-high, bouncing.
- btn_clr  in  1  CLEAR button; raw, active-high, bouncing.
- num1  out  4  latched operand A.
- num2  out  4  latched operand B.
- sum  out  5  registered num1 + num2, zero-extended add.
- sum_valid  out  1  sum is current; display shows it only when high.
- overflow  out  1  sum > 15; qualified by sum_valid.
- blank  out  1  display must blank all digits and LEDs.

## Operation
- **Button path** (per button):
  - 2-flop synchroniser.
  - Debounce counter: cleared whenever the synchronised input equals the debounced level; otherwise increments. When it reaches DEB_COUNT-1, the debounced level takes the synchronised value and the counter clears.
  - Rising edge of the debounced level produces a 1-cycle pulse (calc_p, clr_p).
  - Release edges produce nothing.
- **Switches:**
  - sw_a and sw_b pass through a 2-flop synchroniser only, with no debounce.
  - They are sampled only on calc_p.
- **FSM states:**
  - IDLE: blank=1, sum_valid=0.
  - LOAD: 1 cycle. Operands latched; sum not yet valid.
  - SHOW: sum_valid=1, blank=0.
- **Transitions:**
  - IDLE -calc_p-> LOAD.
  - LOAD -> SHOW (unconditional).
  - SHOW -calc_p-> LOAD (re-sample operands).
  - Any state -clr_p-> IDLE.
  - clr_p and calc_p in the same cycle: clr_p wins, state goes to IDLE.
- **Datapath:**
  - On calc_p: num1 <= sw_a_sync, num2 <= sw_b_sync.
  - In LOAD: sum <= {1'b0,num1} + {1'b0,num2}, overflow <= sum_next[4].
  - On clr_p: num1, num2, sum and overflow all go to 0.
- **Range:**
  - Maximum sum is 15+15 = 30 (5'b11110); no wrap is possible.
  - overflow = 1 exactly when sum >= 16.
- **Stability:** switch changes while in SHOW never alter any output until the next calc_p.

## Timing
- **Reset values** (while clr_n=0): num1=0, num2=0, sum=0, sum_valid=0, overflow=0, blank=1, state IDLE, debounced levels 0, counters 0.
- **Button latency:** a clean press held from cycle 0 gives calc_p at cycle 2 + DEB_COUNT (±1).
- **calc_p at edge N:**
  - state=LOAD and num1/num2 updated after edge N+1.
  - sum, overflow and sum_valid=1 after edge N+2.
- **Re-calc from SHOW:** sum_valid drops for exactly 1 cycle (LOAD), then rises with the new sum.
- **clr_p at edge N:** blank=1, sum_valid=0 and all data zero after edge N+1.
- **Reset mid-debounce:** counter and level are cleared. A button still held at reset release must be stable DEB_COUNT cycles before its pulse fires, so it does fire once.
- **Bounce:** any glitch shorter than DEB_COUNT cycles restarts the counter and produces no pulse.

## Structure
- Package adder_pkg holds:
  - state enum (IDLE, LOAD, SHOW);
  - OP_W=4, SUM_W=5;
  - default DEB_COUNT.
- Sub-module btn_debounce (synchroniser, counter, edge pulse; parameters DEB_COUNT and CNT_W) is instantiated twice.
- Switch synchronisers and the FSM live in the top.

## Test plan
Benches run with DEB_COUNT=4.
1. Reset: clr_n low for 3 cycles -> all outputs at reset values, blank=1; after release, outputs unchanged with no buttons pressed.
2. sw_a=3, sw_b=5, clean calc press -> exactly one calc_p; two cycles later num1=3, num2=5, sum=5'd8, overflow=0, sum_valid=1, blank=0.
3. sw_a=15, sw_b=15, calc -> sum=5'd30, overflow=1. Then sw_a=9, sw_b=6, calc -> sum_valid low for 1 cycle, then sum=5'd15, overflow=0.
4. btn_calc bouncing 1-0-1 with 2-cycle segments, then steady for 10 cycles -> exactly one calc_p and one LOAD; switch changes during SHOW leave sum unchanged.
5. From SHOW with sum=8: btn_clr and btn_calc pressed in the same cycle (identical debounce) -> next state IDLE, blank=1, sum=0, sum_valid=0.
6. clr_n asserted while in LOAD -> outputs immediately return to reset values; btn_calc held across release -> one calc_p after DEB_COUNT+2 cycles.
